ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction fetch unit; sits directly upstream of the execution unit (controller + data path).
- Holds the program counter, reads the instruction memory, and presents one instruction at a time to the execution unit over a valid/ready handshake.
- Consumes the compare flag produced by the execution data path and the jump/branch requests from the controller.
- Redirects the PC and flushes any in-flight fetch when a jump or branch is taken.

Parameters:
- ADDR_W, 8, width of PC and instruction memory address.
- INSTR_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- instr_mem_rd_enb_o  output  1  instruction memory read strobe; single-cycle pulse.
- instr_mem_addr_o  output  ADDR_W  instruction memory read address.
- instr_mem_rd_data_i  input  INSTR_W  read data; qualified by instr_mem_rd_vld_i.
- instr_mem_rd_vld_i  input  1  read data valid; arrives 1 or more cycles after the strobe.
- instr_o  output  INSTR_W  held instruction to the decoder/controller.
- instr_pc_o  output  ADDR_W  address of instr_o.
- instr_vld_o  output  1  instr_o valid.
- instr_rdy_i  input  1  execution unit accepts instr_o.
- jmp_i  input  1  unconditional redirect request, 1-cycle pulse.
- brch_i  input  1  conditional redirect request, 1-cycle pulse.
- tgt_addr_i  input  ADDR_W  redirect target (imm_addr_const field).
- cmp_flag_i  input  1  compare flag from the execution data path.
- halt_i  input  1  level; stop issuing new fetches.
- halted_o  output  1  fetch unit is in HALT.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=REQ; drop flag=0.
  - All outputs 0: instr_o, instr_pc_o, instr_vld_o, instr_mem_rd_enb_o, instr_mem_addr_o, halted_o.
- States: REQ, WAIT, HOLD, HALT.
- REQ:
  - If halt_i=1: no strobe; go to HALT.
  - Otherwise: instr_mem_rd_enb_o=1 and instr_mem_addr_o=pc for this cycle only; go to WAIT.
- WAIT:
  - Stay in WAIT until instr_mem_rd_vld_i=1.
  - On vld with drop=0: register data into instr_o, pc into instr_pc_o, pc<=pc+1 (modulo 2^ADDR_W, 0xFF->0x00); go to HOLD.
  - On vld with drop=1: discard data, clear drop, pc unchanged; go to REQ.
  - instr_mem_rd_vld_i outside WAIT is ignored.
- HOLD:
  - instr_vld_o=1; instr_o and instr_pc_o are stable until the handshake.
  - On instr_vld_o&instr_rdy_i the transfer completes and instr_vld_o=0 next cycle.
  - After the transfer, go to HALT if halt_i=1, else go to REQ.
- HALT:
  - halted_o=1; no strobes.
  - When halt_i=0: go to REQ; halted_o=0 from that cycle.
- Redirect:
  - taken = jmp_i | (brch_i & cmp_flag_i), sampled every cycle in every state.
  - brch_i with cmp_flag_i=0 has no effect.
  - When taken, pc<=tgt_addr_i; this overrides the +1 increment in the same cycle. Per-state effect:
    - REQ: the strobe still issues (old address), set drop=1, go to WAIT.
    - WAIT, data not yet returned: set drop=1; if vld arrives the same cycle, discard that data and go to REQ.
    - HOLD, no handshake: flush; instr_vld_o=0 next cycle; go to REQ, or HALT if halt_i=1.
    - HOLD, handshake in the same cycle: the instruction counts as transferred; go to REQ/HALT with the new pc.
    - HALT: pc updated; stay in HALT.
- Latency and throughput:
  - From REQ to instr_vld_o with a 1-cycle memory: 2 cycles.
  - Steady-state throughput with rdy=1 and 1-cycle memory: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Only one fetch is outstanding at any time. A halt never aborts an outstanding read.
- Reset asserted mid-operation: return to the reset state immediately. A read response arriving after reset deasserts, while the unit is in REQ, is ignored.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory, rdy=1:
  - Strobe at addr 0x00 on cycle 0; instr_vld_o on cycle 2 with instr_pc_o=0x00.
  - Next strobe at 0x01 on cycle 3.
- Back-pressure: rdy=0 for 5 cycles while in HOLD -> instr_o/instr_pc_o stable, no new strobe; rdy=1 -> next strobe on the following cycle.
- Branch in HOLD: brch_i=1, cmp_flag_i=1, tgt=0x40, rdy=0 -> instr_vld_o drops; next strobe addr 0x40. Repeat with cmp_flag_i=0 -> no effect, sequence continues with pc+1.
- Jump during WAIT, 3-cycle memory: jmp_i tgt=0x10 one cycle after the strobe -> returned word discarded, instr_vld_o stays 0, next strobe addr 0x10.
- PC wrap: instruction at 0xFF accepted -> next strobe addr 0x00.
- Halt: halt_i=1 raised in WAIT -> read completes, instruction delivered; after the handshake halted_o=1 and no strobes; halt_i=0 -> REQ, strobe at next pc. Assert rst=0 mid-WAIT -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus: instruction memory read port, instruction hand-off to the
// execution unit, and the redirect/halt controls coming back from it.
interface ifu_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               instr_mem_rd_enb_o;
    logic [ADDR_W-1:0]  instr_mem_addr_o;
    logic [INSTR_W-1:0] instr_mem_rd_data_i;
    logic               instr_mem_rd_vld_i;

    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;
    logic               instr_vld_o;
    logic               instr_rdy_i;

    logic               jmp_i;
    logic               brch_i;
    logic [ADDR_W-1:0]  tgt_addr_i;
    logic               cmp_flag_i;
    logic               halt_i;
    logic               halted_o;

    modport master (
        output instr_mem_rd_enb_o,
        output instr_mem_addr_o,
        input  instr_mem_rd_data_i,
        input  instr_mem_rd_vld_i,
        output instr_o,
        output instr_pc_o,
        output instr_vld_o,
        input  instr_rdy_i,
        input  jmp_i,
        input  brch_i,
        input  tgt_addr_i,
        input  cmp_flag_i,
        input  halt_i,
        output halted_o
    );

    modport slave (
        input  instr_mem_rd_enb_o,
        input  instr_mem_addr_o,
        output instr_mem_rd_data_i,
        output instr_mem_rd_vld_i,
        input  instr_o,
        input  instr_pc_o,
        input  instr_vld_o,
        output instr_rdy_i,
        output jmp_i,
        output brch_i,
        output tgt_addr_i,
        output cmp_flag_i,
        output halt_i,
        input  halted_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one memory read at a time and
// hands each instruction to the execution unit; jumps/taken branches redirect.
module ifu_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic               drop;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               instr_vld_q;
    logic               halted_q;

    logic               taken;
    logic               xfer;
    logic               rd_enb;

    assign taken = bus.jmp_i | (bus.brch_i & bus.cmp_flag_i);
    assign xfer  = instr_vld_q & bus.instr_rdy_i;

    // NOTE: the strobe is decoded from the REQ state so it lands in the REQ
    // cycle itself; gating with rst keeps it low while reset is asserted.
    assign rd_enb = rst & (state == ST_REQ) & ~bus.halt_i;

    assign bus.instr_mem_rd_enb_o = rd_enb;
    assign bus.instr_mem_addr_o   = rd_enb ? pc : '0;
    assign bus.instr_o            = instr_q;
    assign bus.instr_pc_o         = instr_pc_q;
    assign bus.instr_vld_o        = instr_vld_q;
    assign bus.halted_o           = halted_q;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            instr_vld_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // A redirect wins over the sequential increment below, which is
            // only reached when taken is low.
            if (taken) begin
                pc <= bus.tgt_addr_i;
            end

            unique case (state)
                ST_REQ: begin
                    if (bus.halt_i) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                        drop  <= taken;
                    end
                end

                ST_WAIT: begin
                    if (bus.instr_mem_rd_vld_i) begin
                        if (drop || taken) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            instr_q     <= bus.instr_mem_rd_data_i;
                            instr_pc_q  <= pc;
                            pc          <= pc + PC_STEP;
                            instr_vld_q <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (taken) begin
                        drop <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Either a transfer or a flush ends the hold.
                    if (xfer || taken) begin
                        instr_vld_q <= 1'b0;
                        if (bus.halt_i) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end

                ST_HALT: begin
                    if (!bus.halt_i) begin
                        state    <= ST_REQ;
                        halted_q <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule
